// File: rtl/hcs_alarm_manager.sv
// hcs_alarm_manager: debounces healthCareSystem abnormality flags, latches confirmed
// events and presents them one at a time by priority through an alarm/ack handshake.
`default_nettype none

module hcs_alarm_manager #(
  parameter int DEBOUNCE_SAMPLES = 3,
  parameter int GI_LOW           = 2,
  parameter int GI_HIGH          = 12
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       sampleValid,
  input  logic       presureAbnormality,
  input  logic       bloodAbnormality,
  input  logic       fallDetected,
  input  logic       temperatureAbnormality,
  input  logic [3:0] glycemicIndex,
  input  logic       alarmAck,
  output logic       alarm,
  output logic [2:0] alarmCode,
  output logic [4:0] pendingMask,
  output logic [7:0] eventCount
);

  localparam logic [3:0] DEB_MAX = DEBOUNCE_SAMPLES[3:0];
  localparam logic [3:0] DEB_PRE = DEB_MAX - 4'd1;
  localparam logic [3:0] GI_LO   = GI_LOW[3:0];
  localparam logic [3:0] GI_HI   = GI_HIGH[3:0];

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESENT = 2'd1;
  localparam logic [1:0] ACKED   = 2'd2;

  logic [3:0] cnt_q [5];
  logic [3:0] cnt_d [5];
  logic [4:0] pend_q, pend_d;
  logic [7:0] count_q, count_d;
  logic [1:0] state_q, state_d;
  logic [2:0] code_q, code_d;

  logic [4:0] src_abn;
  logic [4:0] confirm;
  logic [4:0] ack_clr;
  logic [8:0] cnt_sum;
  logic [2:0] top_code;

  // Bit order matches alarm code order: bit i is code i+1.
  assign src_abn = {(glycemicIndex < GI_LO) || (glycemicIndex > GI_HI),
                    temperatureAbnormality, bloodAbnormality,
                    presureAbnormality, fallDetected};

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      cnt_d[i]   = cnt_q[i];
      confirm[i] = 1'b0;
      if (sampleValid) begin
        if (src_abn[i]) begin
          if (cnt_q[i] != DEB_MAX) cnt_d[i] = cnt_q[i] + 4'd1;
          confirm[i] = (cnt_q[i] == DEB_PRE);
        end else begin
          cnt_d[i] = 4'd0;
        end
      end
    end
  end

  always_comb begin
    cnt_sum = {1'b0, count_q};
    for (int i = 0; i < 5; i++) cnt_sum = cnt_sum + {8'd0, confirm[i]};
    count_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  always_comb begin
    top_code = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pend_q[i]) top_code = 3'(i + 1);
    end
  end

  // A confirm on the same edge as the ack of that source keeps the bit set.
  always_comb begin
    ack_clr = 5'd0;
    if (state_q == PRESENT && alarmAck) ack_clr = 5'd1 << (code_q - 3'd1);
    pend_d = (pend_q & ~ack_clr) | confirm;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (pend_q != 5'd0) begin
          state_d = PRESENT;
          code_d  = top_code;
        end
      end
      PRESENT: begin
        if (alarmAck) begin
          state_d = ACKED;
          code_d  = 3'd0;
        end
      end
      ACKED:   state_d = IDLE;
      default: begin
        state_d = IDLE;
        code_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < 5; i++) cnt_q[i] <= 4'd0;
      pend_q  <= 5'd0;
      count_q <= 8'd0;
      state_q <= IDLE;
      code_q  <= 3'd0;
    end else begin
      for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
      pend_q  <= pend_d;
      count_q <= count_d;
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  assign alarm       = (state_q == PRESENT);
  assign alarmCode   = code_q;
  assign pendingMask = pend_q;
  assign eventCount  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_hcs_alarm_manager.sv
// Bench for hcs_alarm_manager: vector table, directed corner sequences and
// randomized traffic checked against an event-level reference model.
`default_nettype none

module tb_hcs_alarm_manager;

  localparam int DEB = 3;
  localparam int GLO = 2;
  localparam int GHI = 12;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       sampleValid = 1'b0;
  logic       presureAbnormality = 1'b0;
  logic       bloodAbnormality = 1'b0;
  logic       fallDetected = 1'b0;
  logic       temperatureAbnormality = 1'b0;
  logic [3:0] glycemicIndex = 4'd5;
  logic       alarmAck = 1'b0;
  logic       alarm;
  logic [2:0] alarmCode;
  logic [4:0] pendingMask;
  logic [7:0] eventCount;

  int n_cmp = 0;
  int n_bad = 0;

  hcs_alarm_manager #(.DEBOUNCE_SAMPLES(DEB), .GI_LOW(GLO), .GI_HIGH(GHI)) dut (
    .clk(clk), .rstN(rstN), .sampleValid(sampleValid),
    .presureAbnormality(presureAbnormality), .bloodAbnormality(bloodAbnormality),
    .fallDetected(fallDetected), .temperatureAbnormality(temperatureAbnormality),
    .glycemicIndex(glycemicIndex), .alarmAck(alarmAck),
    .alarm(alarm), .alarmCode(alarmCode), .pendingMask(pendingMask), .eventCount(eventCount)
  );

  always #5 clk = ~clk;

  // Reference model: run lengths per source, a pending set, and the presented alarm.
  int         run [5];
  logic [4:0] m_pend;
  int         m_cnt;
  bit         m_alarm;
  int         m_code;
  bit         m_gap;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) run[i] = 0;
    m_pend = 5'd0; m_cnt = 0; m_alarm = 0; m_code = 0; m_gap = 0;
  endtask

  task automatic model_edge(input logic sv, f, p, b, t, input logic [3:0] gi, input logic ack);
    logic [4:0] old_pend;
    logic [4:0] conf;
    bit         c [5];
    int         n;
    old_pend = m_pend;
    conf = 5'd0;
    n = 0;
    c[0] = f; c[1] = p; c[2] = b; c[3] = t;
    c[4] = (int'(gi) < GLO) || (int'(gi) > GHI);
    for (int i = 0; i < 5; i++) begin
      if (sv) begin
        if (c[i]) begin
          run[i]++;
          if (run[i] == DEB) begin conf[i] = 1'b1; n++; end
        end else begin
          run[i] = 0;
        end
      end
    end
    if (m_alarm && ack) m_pend[m_code-1] = 1'b0;
    m_pend = m_pend | conf;
    m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
    if (m_alarm) begin
      if (ack) begin m_alarm = 0; m_code = 0; m_gap = 1; end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (old_pend != 5'd0) begin
      m_alarm = 1;
      for (int i = 4; i >= 0; i--) if (old_pend[i]) m_code = i + 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic sv, f, p, b, t, input logic [3:0] gi, input logic ack);
    @(negedge clk);
    sampleValid = sv; fallDetected = f; presureAbnormality = p;
    bloodAbnormality = b; temperatureAbnormality = t;
    glycemicIndex = gi; alarmAck = ack;
    @(posedge clk);
    model_edge(sv, f, p, b, t, gi, ack);
    #1;
  endtask

  task automatic idle_step(input logic ack);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, ack);
  endtask

  task automatic do_reset();
    @(negedge clk);
    sampleValid = 0; fallDetected = 0; presureAbnormality = 0; bloodAbnormality = 0;
    temperatureAbnormality = 0; glycemicIndex = 4'd5; alarmAck = 0;
    rstN = 1'b0;
    model_reset();
    @(negedge clk);
    rstN = 1'b1;
  endtask

  typedef struct {
    logic       sv, f, p, b, t;
    logic [3:0] gi;
    logic       ack;
    logic       ea;
    logic [2:0] ec;
    logic [4:0] em;
    logic [7:0] en;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 0, 4'd5, 0, 0, 3'd0, 5'b00000, 8'd0};
    tbl[1]  = '{1, 1, 0, 0, 0, 4'd5, 0, 0, 3'd0, 5'b00000, 8'd0};
    tbl[2]  = '{1, 1, 0, 0, 0, 4'd5, 0, 0, 3'd0, 5'b00001, 8'd1};
    tbl[3]  = '{0, 1, 0, 0, 0, 4'd5, 0, 1, 3'd1, 5'b00001, 8'd1};
    tbl[4]  = '{0, 1, 0, 0, 0, 4'd5, 1, 0, 3'd0, 5'b00000, 8'd1};
    tbl[5]  = '{0, 1, 0, 0, 0, 4'd5, 0, 0, 3'd0, 5'b00000, 8'd1};
    tbl[6]  = '{1, 1, 0, 0, 0, 4'd5, 0, 0, 3'd0, 5'b00000, 8'd1};
    tbl[7]  = '{1, 0, 0, 0, 0, 4'd5, 0, 0, 3'd0, 5'b00000, 8'd1};
    tbl[8]  = '{1, 0, 1, 0, 0, 4'd5, 0, 0, 3'd0, 5'b00000, 8'd1};
    tbl[9]  = '{1, 0, 1, 0, 0, 4'd5, 0, 0, 3'd0, 5'b00000, 8'd1};
    tbl[10] = '{1, 0, 0, 0, 0, 4'd5, 0, 0, 3'd0, 5'b00000, 8'd1};
    tbl[11] = '{1, 0, 1, 0, 0, 4'd5, 0, 0, 3'd0, 5'b00000, 8'd1};
    tbl[12] = '{1, 0, 1, 0, 0, 4'd5, 0, 0, 3'd0, 5'b00000, 8'd1};

    do_reset();
    #1;
    chk("reset_alarm", alarm, 0);
    chk("reset_code", alarmCode, 0);
    chk("reset_mask", pendingMask, 0);
    chk("reset_count", eventCount, 0);

    // Table: fall debounce, ack, saturated counter, broken pressure run
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].sv, tbl[i].f, tbl[i].p, tbl[i].b, tbl[i].t, tbl[i].gi, tbl[i].ack);
      chk($sformatf("tbl%0d_alarm", i), alarm, tbl[i].ea);
      chk($sformatf("tbl%0d_code", i), alarmCode, tbl[i].ec);
      chk($sformatf("tbl%0d_mask", i), pendingMask, tbl[i].em);
      chk($sformatf("tbl%0d_count", i), eventCount, tbl[i].en);
    end

    // Simultaneous blood + glycemic confirm, presented by priority
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 4'd15, 0);
    chk("dual_mask", pendingMask, 5'b10100);
    chk("dual_count", eventCount, 2);
    chk("dual_noalarm", alarm, 0);
    idle_step(0);
    chk("dual_code3", alarmCode, 3);
    chk("dual_alarm3", alarm, 1);
    idle_step(1);
    chk("dual_acked_alarm", alarm, 0);
    chk("dual_acked_code", alarmCode, 0);
    chk("dual_mask_after1", pendingMask, 5'b10000);
    idle_step(1);
    chk("dual_idle_alarm", alarm, 0);
    idle_step(0);
    chk("dual_code5", alarmCode, 5);
    idle_step(1);
    chk("dual_mask_clear", pendingMask, 0);
    chk("dual_final_alarm", alarm, 0);

    // Glycemic boundaries are exclusive
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 4'd1, 0);
    chk("gi1_count", eventCount, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 4'd12, 0);
    chk("gi12_count", eventCount, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 4'd13, 0);
    chk("gi13_count", eventCount, 2);

    // Presented code frozen while a higher-priority event arrives
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 4'd5, 0);
    idle_step(0);
    chk("frz_code4", alarmCode, 4);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0, 0, 4'd5, 0);
      chk($sformatf("frz_hold%0d", i), alarmCode, 4);
    end
    chk("frz_mask", pendingMask, 5'b01001);
    idle_step(1);
    chk("frz_ack_alarm", alarm, 0);
    idle_step(0);
    chk("frz_gap_alarm", alarm, 0);
    idle_step(0);
    chk("frz_code1", alarmCode, 1);
    chk("frz_alarm1", alarm, 1);

    // Long hold gives one event; toggling saturates the count
    do_reset();
    for (int i = 0; i < 300; i++) step(1, 0, 0, 0, 1, 4'd5, 0);
    chk("hold_count", eventCount, 1);
    step(1, 0, 0, 0, 0, 4'd5, 0);
    for (int k = 0; k < 260; k++) begin
      for (int j = 0; j < 3; j++) step(1, 0, 0, 0, 1, 4'd5, 0);
      step(1, 0, 0, 0, 0, 4'd5, 0);
      if (k == 252) chk("sat_pre", eventCount, 254);
    end
    chk("sat_count", eventCount, 255);

    // Asynchronous reset while presenting
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 4'd5, 0);
    idle_step(0);
    chk("ar_pre_alarm", alarm, 1);
    #2;
    rstN = 1'b0;
    #1;
    chk("ar_alarm", alarm, 0);
    chk("ar_code", alarmCode, 0);
    chk("ar_mask", pendingMask, 0);
    chk("ar_count", eventCount, 0);
    model_reset();
    @(negedge clk);
    rstN = 1'b1;
    idle_step(0);
    chk("ar_no_resume", alarm, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0));
      chk("rnd_alarm", alarm, m_alarm);
      chk("rnd_code", alarmCode, m_code);
      chk("rnd_mask", pendingMask, m_pend);
      chk("rnd_count", eventCount, m_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hcs_alarm_manager.md
Name: hcs_alarm_manager

Overview:
- Sequential stage directly downstream of healthCareSystem.
- Consumes its four abnormality flags and its 4-bit glycemicIndex, once per sample strobe.
- Debounces each source and latches confirmed events into a pending set.
- Presents pending events one at a time, highest priority first, to the nurse-station interface through an alarm/acknowledge handshake, and keeps a saturating event count.

Parameters:
- DEBOUNCE_SAMPLES, 3, consecutive asserted valid samples needed to confirm an event (range 1..15).
- GI_LOW, 2, glycemicIndex strictly below this value is abnormal.
- GI_HIGH, 12, glycemicIndex strictly above this value is abnormal.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- sampleValid  in  1  one-cycle strobe; the other inputs are sampled only when it is high.
- presureAbnormality  in  1  from healthCareSystem.
- bloodAbnormality  in  1  from healthCareSystem.
- fallDetected  in  1  from healthCareSystem.
- temperatureAbnormality  in  1  from healthCareSystem.
- glycemicIndex  in  4  from healthCareSystem.
- alarmAck  in  1  acknowledge from the nurse station.
- alarm  out  1  an alarm is being presented.
- alarmCode  out  3  code of the presented alarm; 0 = none.
- pendingMask  out  5  latched unacknowledged events; bit i corresponds to code i+1.
- eventCount  out  8  total confirmed events, saturating.

Behaviour:
- Reset: asynchronous, active low; one clock domain only. While rstN=0, every register clears immediately:
  - alarm=0, alarmCode=0, pendingMask=0, eventCount=0.
  - All debounce counters = 0; FSM = IDLE.
  - Reset asserted mid-alarm drops alarm at once. Nothing resumes after release.
- Sources and codes, in priority order (highest first):
  - 1 fallDetected.
  - 2 presureAbnormality.
  - 3 bloodAbnormality.
  - 4 temperatureAbnormality.
  - 5 glycemic, abnormal when glycemicIndex < GI_LOW or glycemicIndex > GI_HIGH. Unsigned 4-bit compare.
- Debounce: one 4-bit counter per source, updated only on edges where sampleValid=1.
  - Source condition true: counter increments and saturates at DEBOUNCE_SAMPLES.
  - Source condition false: counter clears to 0.
  - sampleValid=0: all counters hold.
- Confirmed event: fires on the edge where a counter goes from DEBOUNCE_SAMPLES-1 to DEBOUNCE_SAMPLES.
  - Fires exactly once per continuous abnormal run.
  - Does not refire until the condition drops and the counter rebuilds.
- Pending set: a confirmed event sets its pendingMask bit on that same edge.
  - Setting an already-set bit has no further effect on pendingMask; eventCount still increments.
- eventCount: adds the number of events confirmed on the edge (0..5) and saturates at 255.
- FSM states:
  - IDLE: alarm=0, alarmCode=0. If pendingMask≠0, go to PRESENT and latch alarmCode = highest-priority pending code.
  - PRESENT: alarm=1. alarmCode is frozen while in this state, even if a higher-priority event arrives. On alarmAck=1: clear the pendingMask bit of alarmCode and go to ACKED.
  - ACKED: alarm=0, alarmCode=0 for exactly one cycle, then return to IDLE. alarmAck is ignored here.
- Latency:
  - Nth valid abnormal sample at edge E sets pending at E; alarm rises at E+1.
  - After an ack at edge A, the next pending alarm is presented at A+2 (ACKED, then IDLE→PRESENT).
- Ack outside PRESENT is ignored. Ack held high for several cycles acknowledges only one alarm per PRESENT entry.
- Simultaneous confirm and ack of the same source on one edge: set wins. The bit stays pending and is re-presented.
- alarmAck and sampleValid in the same cycle are both processed independently.

Test Plan:
- Reset, then 3 consecutive sampleValid pulses with fallDetected=1 → pendingMask=5'b00001 after the 3rd; next cycle alarm=1, alarmCode=1; eventCount=1.
- presureAbnormality=1 for 2 valid samples, 0 for 1, then 1 for 2 → no event, alarm stays 0, eventCount=0.
- Same edge confirms bloodAbnormality and glycemicIndex=15 → pendingMask=5'b10100, eventCount=2.
  - Present code 3; ack → ACKED for 1 cycle; then code 5 presented; ack → IDLE, pendingMask=0.
- glycemicIndex=1, 12, then 13 tested as 3-sample runs → events for 1 and 13 only (boundaries exclusive).
- While alarmCode=4 is presented, confirm a fall event → alarmCode stays 4 until ack; code 1 is presented 2 cycles after the ack.
- Hold temperatureAbnormality=1 for 300 valid samples with no ack → exactly 1 event. Then toggle it to generate 260 events → eventCount saturates at 255.
- Pull rstN low while alarm=1 → alarm, alarmCode, pendingMask and eventCount clear immediately, without waiting for a clock edge.
